jk_seq_driver: RTL and testbench

- Drives the J/K inputs of an external JK flip-flop so that its Q output follows a loaded target bit sequence.
- Computes the J/K pair for each step from the JK excitation table.
- Samples the flip-flop's Q as feedback and checks it against each target bit, counting mismatches.
- Used as a stimulus/self-check engine for JK flip-flop blocks and as a simple pattern-to-JK encoder in larger designs.

---
 rtl/jk_seq_driver.sv | 168 ++++++++++++++++
 tb/tb_jk_seq_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_seq_driver.sv
// Drives J/K of an external JK flip-flop so its Q follows a loaded bit sequence,
// and checks the flip-flop's Q feedback against each target bit.
module jk_seq_driver #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DC_FILL = 0,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [LEN_W-1:0] err_count
);

  localparam logic             DC_BIT  = (DC_FILL != 0);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] err_d;
  logic             j_d, k_d, busy_d, done_d, mm_d;

  logic [LEN_W-1:0] len_clamp_c;
  logic [LEN_W-1:0] nxt_idx_c;
  logic [LEN_W-1:0] cmp_sel_c;
  logic [WIDTH-1:0] cmp_sh_c, cur_sh_c, prev_sh_c;
  logic             cmp_bit_c, cur_bit_c, prev_bit_c;
  logic             cmp_en_c, miss_c;
  logic [1:0]       exc_c;

  // JK excitation for a prev->cur Q transition; don't-cares resolved by DC_BIT.
  function automatic logic [1:0] excite(input logic prev, input logic cur);
    logic [1:0] code;
    case ({prev, cur})
      2'b00:   code = {1'b0, DC_BIT};
      2'b01:   code = {1'b1, DC_BIT};
      2'b10:   code = {DC_BIT, 1'b1};
      default: code = {DC_BIT, 1'b0};
    endcase
    return code;
  endfunction

  // Bit selection through shifts keeps index widths independent of WIDTH.
  always_comb begin
    len_clamp_c = (len > LEN_MAX) ? LEN_MAX : len;
    nxt_idx_c   = idx_q + LEN_W'(1);
    cmp_sel_c   = (state_q == S_DRAIN) ? (len_q - LEN_W'(1)) : (idx_q - LEN_W'(1));
    cmp_sh_c    = pat_q >> cmp_sel_c;
    cur_sh_c    = pat_q >> nxt_idx_c;
    prev_sh_c   = pat_q >> idx_q;
    cmp_bit_c   = cmp_sh_c[0];
    cur_bit_c   = cur_sh_c[0];
    prev_bit_c  = prev_sh_c[0];
    cmp_en_c    = (state_q == S_DRAIN) || ((state_q == S_DRIVE) && (idx_q != '0));
    miss_c      = cmp_en_c && (q_fb != cmp_bit_c);
    exc_c       = excite(prev_bit_c, cur_bit_c);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    mm_d    = mismatch;
    err_d   = err_count;

    if (miss_c) begin
      mm_d = 1'b1;
      if (err_count != '1) err_d = err_count + LEN_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d  = pattern;
          len_d  = len_clamp_c;
          idx_d  = '0;
          busy_d = 1'b1;
          mm_d   = 1'b0;
          err_d  = '0;
          if (len_clamp_c == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_DRIVE;
            // Q is unknown before the first step, so force it with set/reset.
            j_d     = pattern[0];
            k_d     = ~pattern[0];
          end
        end
      end
      S_DRIVE: begin
        if (nxt_idx_c < len_q) begin
          idx_d = nxt_idx_c;
          j_d   = exc_c[1];
          k_d   = exc_c[0];
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_FIN;
        done_d  = 1'b1;
      end
      S_FIN: begin
        // An empty run enters here without done set; hold one cycle to pulse it.
        if (done) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      j         <= j_d;
      k         <= k_d;
      busy      <= busy_d;
      done      <= done_d;
      mismatch  <= mm_d;
      err_count <= err_d;
    end
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Scoreboard bench for jk_seq_driver: two instances (DC_FILL 0 and 1), each
// closing the loop through a behavioural JK flip-flop.
module tb_jk_seq_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       tie0;

  logic       j0, k0, busy0, done0, mm0;
  logic [3:0] err0;
  logic       j1, k1, busy1, done1, mm1;
  logic [3:0] err1;
  logic       q0_ff = 1'b0;
  logic       q1_ff = 1'b0;
  logic       qfb0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] jk0;
    logic [1:0] jk1;
    logic       done;
    logic       busy;
    logic       chk_busy;
    logic       chk_err;
    logic [3:0] err0;
    logic [3:0] err1;
    logic       mm0;
    logic       mm1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign qfb0 = tie0 ? 1'b0 : q0_ff;

  jk_seq_driver #(.WIDTH(8), .DC_FILL(0), .LEN_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .q_fb(qfb0), .j(j0), .k(k0), .busy(busy0), .done(done0),
    .mismatch(mm0), .err_count(err0)
  );

  jk_seq_driver #(.WIDTH(8), .DC_FILL(1), .LEN_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .q_fb(q1_ff), .j(j1), .k(k1), .busy(busy1), .done(done1),
    .mismatch(mm1), .err_count(err1)
  );

  // Behavioural JK flip-flops driven by each DUT.
  always @(posedge clk) begin
    case ({j0, k0})
      2'b10:   q0_ff <= 1'b1;
      2'b01:   q0_ff <= 1'b0;
      2'b11:   q0_ff <= ~q0_ff;
      default: q0_ff <= q0_ff;
    endcase
    case ({j1, k1})
      2'b10:   q1_ff <= 1'b1;
      2'b01:   q1_ff <= 1'b0;
      2'b11:   q1_ff <= ~q1_ff;
      default: q1_ff <= q1_ff;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference J/K for step i: step 0 forces Q, later steps follow the excitation table.
  function automatic logic [1:0] exp_jk(input logic [7:0] pat, input int i, input logic dc);
    logic jj, kk, prev, cur;
    if (i == 0) begin
      jj = pat[0];
      kk = ~pat[0];
    end else begin
      prev = pat[i-1];
      cur  = pat[i];
      jj   = prev ? dc : cur;
      kk   = prev ? ~cur : dc;
    end
    return {jj, kk};
  endfunction

  // Per-cycle scoreboard monitor, sampling at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("jk0", 32'({j0, k0}), 32'(e.jk0));
      check("jk1", 32'({j1, k1}), 32'(e.jk1));
      check("done0", 32'(done0), 32'(e.done));
      check("done1", 32'(done1), 32'(e.done));
      if (e.chk_busy) begin
        check("busy0", 32'(busy0), 32'(e.busy));
        check("busy1", 32'(busy1), 32'(e.busy));
      end
      if (e.chk_err) begin
        check("err0", 32'(err0), 32'(e.err0));
        check("mm0", 32'(mm0), 32'(e.mm0));
        check("err1", 32'(err1), 32'(e.err1));
        check("mm1", 32'(mm1), 32'(e.mm1));
      end
    end
  end

  task automatic push_run(input logic [7:0] pat, input logic [3:0] ln, input bit t0);
    exp_t e;
    int   eff;
    int   ones;
    eff  = (ln > 4'd8) ? 8 : int'(ln);
    ones = 0;
    for (int i = 0; i < eff; i++) begin
      e = '{jk0: exp_jk(pat, i, 1'b0), jk1: exp_jk(pat, i, 1'b1), done: 1'b0,
            busy: 1'b1, chk_busy: 1'b1, chk_err: 1'b0,
            err0: 4'd0, err1: 4'd0, mm0: 1'b0, mm1: 1'b0};
      sb.push_back(e);
      if (pat[i]) ones++;
    end
    // Drain cycle, or the extra FIN cycle of an empty run.
    e = '{jk0: 2'b00, jk1: 2'b00, done: 1'b0, busy: 1'b1, chk_busy: 1'b1,
          chk_err: 1'b0, err0: 4'd0, err1: 4'd0, mm0: 1'b0, mm1: 1'b0};
    sb.push_back(e);
    e = '{jk0: 2'b00, jk1: 2'b00, done: 1'b1, busy: 1'b0, chk_busy: 1'b0,
          chk_err: 1'b1, err0: t0 ? 4'(ones) : 4'd0, err1: 4'd0,
          mm0: t0 && (ones != 0), mm1: 1'b0};
    sb.push_back(e);
    e = '{jk0: 2'b00, jk1: 2'b00, done: 1'b0, busy: 1'b0, chk_busy: 1'b1,
          chk_err: 1'b0, err0: 4'd0, err1: 4'd0, mm0: 1'b0, mm1: 1'b0};
    sb.push_back(e);
  endtask

  task automatic launch(input logic [7:0] pat, input logic [3:0] ln, input bit t0);
    @(posedge clk); #1;
    tie0    = t0;
    pattern = pat;
    len     = ln;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    pattern = ~pat;
    len     = 4'd3;
    push_run(pat, ln, t0);
  endtask

  task automatic run_seq(input logic [7:0] pat, input logic [3:0] ln, input bit t0, input int glitch);
    launch(pat, ln, t0);
    for (int c = 1; c <= 40 && sb.size() > 0; c++) begin
      @(posedge clk); #1;
      start = (c == glitch);
    end
    start = 1'b0;
    if (sb.size() > 0) begin
      check("run_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    pattern = 8'h00;
    len     = 4'd0;
    tie0    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_jk0", 32'({j0, k0}), 32'd0);
    check("rst_jk1", 32'({j1, k1}), 32'd0);
    check("rst_busy", 32'({busy0, busy1}), 32'd0);
    check("rst_done", 32'({done0, done1}), 32'd0);
    check("rst_mm", 32'({mm0, mm1}), 32'd0);
    check("rst_err", 32'({err0, err1}), 32'd0);

    // Nominal run, both don't-care fills.
    run_seq(8'hB2, 4'd8, 1'b0, 0);

    // Feedback stuck at 0 on the DC_FILL=0 instance; results hold in IDLE.
    run_seq(8'hB2, 4'd8, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("hold_mm0", 32'(mm0), 32'd1);
    check("hold_err0", 32'(err0), 32'd4);

    // Empty run and over-length clamp.
    run_seq(8'hB2, 4'd0, 1'b0, 0);
    run_seq(8'hB2, 4'd12, 1'b0, 0);

    // Start during drive step 3 is ignored; this run also clears the stale errors.
    run_seq(8'hB2, 4'd8, 1'b1, 0);
    run_seq(8'hB2, 4'd8, 1'b0, 3);

    // Reset during drive step 4 aborts without a done pulse.
    launch(8'hB2, 4'd8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_jk0", 32'({j0, k0}), 32'd0);
    check("abort_jk1", 32'({j1, k1}), 32'd0);
    check("abort_busy", 32'({busy0, busy1}), 32'd0);
    check("abort_mm", 32'({mm0, mm1}), 32'd0);
    check("abort_err", 32'({err0, err1}), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("abort_done", 32'({done0, done1}), 32'd0);
      @(negedge clk);
    end
    run_seq(8'hB2, 4'd8, 1'b0, 0);

    // A few random patterns and lengths, with and without stuck feedback.
    for (int r = 0; r < 6; r++) begin
      run_seq(8'($urandom), 4'($urandom_range(1, 10)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
